alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  Pipeline/skid stage directly upstream of the ALU. Accepts decoded operands plus
//  ALU control over a valid/ready handshake, and presents them registered to the
//  ALU src1/src2/ctrl inputs. Patches stale operands with the write-back result
//  (forwarding) while an entry waits. Absorbs one cycle of downstream stall
//  without dropping data (2-entry skid).
// PARAMETERS
//  DATA_W   32  operand/result width
//  CTRL_W   4   ALU control width (0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt)
//  REG_AW   5   register index width; index 0 is never forwarded
// PORTS
//  clk_i        in   1       clock, all state updates on rising edge
//  rst_i        in   1       reset, asynchronous, active-low
//  flush_i      in   1       drop all held entries at next edge
//  in_valid_i   in   1       upstream entry valid
//  in_ready_o   out  1       stage can accept this cycle
//  in_src1_i    in   DATA_W  operand 1 read from register file
//  in_src2_i    in   DATA_W  operand 2 (register or immediate)
//  in_rs_i      in   REG_AW  source index of src1
//  in_rt_i      in   REG_AW  source index of src2; in_rt_i==0 when src2 is immediate
//  in_ctrl_i    in   CTRL_W  ALU operation
//  in_rd_i      in   REG_AW  destination index
//  in_wen_i     in   1       entry writes rd
//  fwd_valid_i  in   1       write-back in progress this cycle
//  fwd_rd_i     in   REG_AW  write-back destination
//  fwd_data_i   in   DATA_W  write-back value
//  out_valid_o  out  1       src1_o..wen_o valid for ALU
//  out_ready_i  in   1       downstream consumes this cycle
//  src1_o       out  DATA_W  to ALU src1
//  src2_o       out  DATA_W  to ALU src2
//  ctrl_o       out  CTRL_W  to ALU ctrl
//  rd_o         out  REG_AW  destination carried alongside
//  wen_o        out  1       write enable carried alongside
// BEHAVIOUR
//  - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//  - Storage: main entry (drives outputs) + skid entry; each holds src1, src2, rs, rt,
//    ctrl, rd, wen.
//  - in_ready_o = !skid_valid (registered state only; no combinational path from
//    out_ready_i).
//  - States: EMPTY (no entry), ONE (main valid), TWO (main+skid valid).
//      EMPTY: push -> ONE (main<=in)
//      ONE: push&pop -> ONE (main<=in); push&!pop -> TWO (skid<=in);
//           !push&pop -> EMPTY
//      TWO: (no push possible) pop -> ONE (main<=skid); else hold
//  - flush_i=1: next state EMPTY, any simultaneous push is discarded; flush wins over
//    everything except reset.
//  - Latency: accepted entry is on outputs the cycle after push (from EMPTY/ONE-with-pop).
//    Throughput is 1 entry/cycle. Entries leave in strict arrival order.
//  - Forwarding match = fwd_valid_i & (fwd_rd_i!=0) & (fwd_rd_i==index).
//    - On push: src1 <= fwd_data_i if match on in_rs_i; same for src2/in_rt_i.
//    - Every cycle: held main and skid entries replace src1/src2 on match of their
//      stored rs/rt (both fields may match at once; both are replaced).
//    - Moving skid->main in the same cycle as a match stores the patched value.
//  - Operands pass through unmodified otherwise: no width change, no sign extension.
//  - When out_valid_o=0, data outputs hold their last value (don't care).
//  - Reset (rst_i=0, any time incl. mid-stall): state EMPTY; out_valid_o=0;
//    in_ready_o=1; src1_o=src2_o=0; ctrl_o=0; rd_o=0; wen_o=0. Held entries are lost.
// TESTING
//  1 Reset then push {src1=5,src2=3,ctrl=0010} with out_ready_i=1 -> next cycle
//    out_valid_o=1, src1_o=5, src2_o=3, ctrl_o=0010; following cycle out_valid_o=0.
//  2 Stream 4 entries back-to-back with out_ready_i=1 -> outputs in order, one per
//    cycle, in_ready_o stays 1.
//  3 out_ready_i=0, push A then B -> in_ready_o=0 after B; release -> A then B
//    emerge on consecutive cycles; no loss, no duplicate.
//  4 Entry rs=7 held in stall, fwd_valid_i=1, fwd_rd_i=7, fwd_data_i=0xDEAD ->
//    src1_o=0xDEAD next cycle. Same with fwd_rd_i=0 -> src1_o unchanged.
//  5 State TWO, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0,
//    in_ready_o=1, the pushed entry never appears.
//  6 Assert rst_i=0 asynchronously mid-stall -> outputs zero immediately, no clock
//    edge needed.

Source files
------------

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Two-entry skid stage sitting directly in front of the ALU. Decoded operands
// and ALU control arrive over a valid/ready handshake and are presented
// registered on src1_o/src2_o/ctrl_o together with the destination index and
// write enable. While an entry waits in the stage, a write-back that targets
// one of its source registers replaces the stale operand (forwarding). One
// cycle of downstream stall is absorbed without loss because in_ready_o
// depends only on registered state.
//
// Ports
//   clk_i                  clock, rising edge
//   rst_i                  asynchronous reset, active low
//   flush_i                drop every held entry at the next edge
//   in_valid_i/in_ready_o  upstream handshake
//   in_src1_i, in_src2_i   operands (src2 may be an immediate)
//   in_rs_i, in_rt_i       source indices of src1/src2 (rt==0 for immediates)
//   in_ctrl_i              ALU operation
//   in_rd_i, in_wen_i      destination index and write enable
//   fwd_valid_i            write-back in progress this cycle
//   fwd_rd_i, fwd_data_i   write-back destination and value
//   out_valid_o/out_ready_i downstream handshake
//   src1_o, src2_o, ctrl_o operands and control to the ALU
//   rd_o, wen_o            destination carried alongside
// -----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_src1_i,
    input  logic [DATA_W-1:0] in_src2_i,
    input  logic [REG_AW-1:0] in_rs_i,
    input  logic [REG_AW-1:0] in_rt_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [REG_AW-1:0] in_rd_i,
    input  logic              in_wen_i,
    input  logic              fwd_valid_i,
    input  logic [REG_AW-1:0] fwd_rd_i,
    input  logic [DATA_W-1:0] fwd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] src1_o,
    output logic [DATA_W-1:0] src2_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              wen_o
);

    typedef struct packed {
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rd;
        logic              wen;
    } entry_t;

    // ST_TWO means main and skid are both occupied; skid is never valid alone.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry, in_fwd, main_fwd, skid_fwd;
    logic   push, pop;

    // Register 0 is hard-wired, so a write-back to it never forwards.
    function automatic logic fwd_hit(input logic              valid,
                                     input logic [REG_AW-1:0] wb_rd,
                                     input logic [REG_AW-1:0] idx);
        return valid && (wb_rd != '0) && (wb_rd == idx);
    endfunction

    // Both operand fields are checked independently; rs==rt patches both.
    function automatic entry_t fwd_patch(input entry_t              e,
                                         input logic                valid,
                                         input logic [REG_AW-1:0]   wb_rd,
                                         input logic [DATA_W-1:0]   wb_data);
        entry_t r;
        r = e;
        if (fwd_hit(valid, wb_rd, e.rs)) r.src1 = wb_data;
        if (fwd_hit(valid, wb_rd, e.rt)) r.src2 = wb_data;
        return r;
    endfunction

    // Ready comes from registered state only, so there is no combinational
    // path from out_ready_i back to in_ready_o.
    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    assign in_entry = '{src1: in_src1_i, src2: in_src2_i, rs: in_rs_i,
                        rt: in_rt_i, ctrl: in_ctrl_i, rd: in_rd_i,
                        wen: in_wen_i};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        in_fwd   = fwd_patch(in_entry, fwd_valid_i, fwd_rd_i, fwd_data_i);
        main_fwd = main_q;
        skid_fwd = skid_q;
        if (state_q != ST_EMPTY)
            main_fwd = fwd_patch(main_q, fwd_valid_i, fwd_rd_i, fwd_data_i);
        if (state_q == ST_TWO)
            skid_fwd = fwd_patch(skid_q, fwd_valid_i, fwd_rd_i, fwd_data_i);

        state_d = state_q;
        main_d  = main_fwd;
        skid_d  = skid_fwd;

        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    main_d  = in_fwd;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_d = in_fwd;
                end else if (push) begin
                    skid_d  = in_fwd;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // The skid entry moves up carrying any forward seen this cycle.
                if (pop) begin
                    main_d  = skid_fwd;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush only empties the stage; stored data becomes don't-care and is
        // left as is, so a simultaneous push simply never becomes visible.
        if (flush_i) state_d = ST_EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values computed before this edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the entry registers are reset as well because the main entry
    // drives the outputs directly and they must read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign src1_o = main_q.src1;
    assign src2_o = main_q.src2;
    assign ctrl_o = main_q.ctrl;
    assign rd_o   = main_q.rd;
    assign wen_o  = main_q.wen;

endmodule
